// File: rtl/cache_fill_fsm_if.sv
// Bundles the cache fill FSM's miss request, memory return and data/tag
// array write signals. The FSM connects through the slave modport; the
// cache controller / memory side connects through the master modport.
interface cache_fill_fsm_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        victim_way;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_en0;
  logic        write_en1;
  logic [63:0] set_enable;
  logic [7:0]  word_enable;
  logic [15:0] data_out;
  logic        write_tag_array;
  logic        fill_done;

  modport master (
    output miss_detected, miss_address, victim_way, memory_data_valid, memory_data,
    input  fsm_busy, mem_read_en, memory_address, write_en0, write_en1,
           set_enable, word_enable, data_out, write_tag_array, fill_done
  );

  modport slave (
    input  miss_detected, miss_address, victim_way, memory_data_valid, memory_data,
    output fsm_busy, mem_read_en, memory_address, write_en0, write_en1,
           set_enable, word_enable, data_out, write_tag_array, fill_done
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Two-way cache block fill sequencer. On a miss it issues eight word read
// requests for the 16-byte block and writes each returned word (in request
// order) into the selected way of the data array, then strobes the tag array.
module cache_fill_fsm #(
  parameter int WORDS = 8
) (
  input logic           clk,
  input logic           rst,
  cache_fill_fsm_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  localparam logic [3:0] REQ_LIMIT = 4'(WORDS);
  localparam logic [2:0] LAST_WORD = 3'(WORDS - 1);

  // Decode a set index into the one-hot data array set select.
  function automatic logic [63:0] set_onehot(input logic [5:0] idx);
    set_onehot = 64'd1 << idx;
  endfunction

  // Decode a word offset into the one-hot data array word select.
  function automatic logic [7:0] word_onehot(input logic [2:0] idx);
    word_onehot = 8'd1 << idx;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  req_cnt_q, req_cnt_d;
  logic [2:0]  recv_cnt_q, recv_cnt_d;
  logic [11:0] blk_addr_q, blk_addr_d;
  logic        way_q, way_d;

  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_en0;
  logic        write_en1;
  logic [63:0] set_enable;
  logic [7:0]  word_enable;
  logic [15:0] data_out;
  logic        write_tag_array;
  logic        fill_done;

  // State, counters and latched miss context; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_cnt_q  <= 4'd0;
      recv_cnt_q <= 3'd0;
      blk_addr_q <= 12'd0;
      way_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      recv_cnt_q <= recv_cnt_d;
      blk_addr_q <= blk_addr_d;
      way_q      <= way_d;
    end
  end

  // Next-state and output decode; every output is gated by FILL so IDLE is all-zero.
  always_comb begin
    state_d         = state_q;
    req_cnt_d       = req_cnt_q;
    recv_cnt_d      = recv_cnt_q;
    blk_addr_d      = blk_addr_q;
    way_d           = way_q;
    mem_read_en     = 1'b0;
    memory_address  = 16'd0;
    write_en0       = 1'b0;
    write_en1       = 1'b0;
    set_enable      = 64'd0;
    word_enable     = 8'd0;
    data_out        = 16'd0;
    write_tag_array = 1'b0;
    fill_done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.miss_detected) begin
          state_d    = S_FILL;
          blk_addr_d = bus.miss_address[15:4];
          way_d      = bus.victim_way;
        end else begin
          state_d    = S_IDLE;
        end
      end

      S_FILL: begin
        // Request side: one read per cycle until all words have been asked for.
        if (req_cnt_q < REQ_LIMIT) begin
          mem_read_en    = 1'b1;
          memory_address = {blk_addr_q, req_cnt_q[2:0], 1'b0};
          req_cnt_d      = req_cnt_q + 4'd1;
        end else begin
          mem_read_en    = 1'b0;
        end

        // Return side: words come back in order, so recv_cnt is the word offset.
        if (bus.memory_data_valid) begin
          write_en0   = ~way_q;
          write_en1   = way_q;
          set_enable  = set_onehot(blk_addr_q[5:0]);
          word_enable = word_onehot(recv_cnt_q);
          data_out    = bus.memory_data;
          if (recv_cnt_q == LAST_WORD) begin
            write_tag_array = 1'b1;
            fill_done       = 1'b1;
            state_d         = S_IDLE;
            req_cnt_d       = 4'd0;
            recv_cnt_d      = 3'd0;
          end else begin
            recv_cnt_d      = recv_cnt_q + 3'd1;
          end
        end else begin
          recv_cnt_d = recv_cnt_q;
        end
      end

      default: begin
        state_d    = S_IDLE;
        req_cnt_d  = 4'd0;
        recv_cnt_d = 3'd0;
      end
    endcase
  end

  assign bus.fsm_busy        = (state_q == S_FILL);
  assign bus.mem_read_en     = mem_read_en;
  assign bus.memory_address  = memory_address;
  assign bus.write_en0       = write_en0;
  assign bus.write_en1       = write_en1;
  assign bus.set_enable      = set_enable;
  assign bus.word_enable     = word_enable;
  assign bus.data_out        = data_out;
  assign bus.write_tag_array = write_tag_array;
  assign bus.fill_done       = fill_done;

endmodule
